// File: rtl/cache_mem_responder.sv
// Word-addressed RAM responder for the dcache/icache bus with fixed access latency LAT.
// Optional round-robin arbitration between ports: define CACHE_MEM_RR_ARB_EN.
module cache_mem_responder #(
  parameter int LAT    = 2,
  parameter int MEM_AW = 8
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        dREN,
  input  logic        dWEN,
  input  logic [31:0] daddr,
  input  logic [31:0] dstore,
  output logic        dwait,
  output logic [31:0] dload,
  input  logic        iREN,
  input  logic [31:0] iaddr,
  output logic        iwait,
  output logic [31:0] iload
);

  typedef enum logic [1:0] {IDLE, D_BUSY, I_BUSY} state_t;

  localparam int unsigned DEPTH = 1 << MEM_AW;
  localparam logic [3:0]  LAT_C = 4'(LAT);

  state_t            r_state, w_state_nxt;
  logic [3:0]        r_cnt, w_cnt_nxt;
  logic [MEM_AW-1:0] r_idx, w_idx_nxt;
  logic              r_wr, w_wr_nxt;
  logic [31:0]       r_mem [DEPTH];
  logic              w_mem_we;

  logic              w_d_req;
  logic [MEM_AW-1:0] w_d_idx;
  logic [MEM_AW-1:0] w_i_idx;
  logic              w_grant_d;
  logic              w_unused;

  assign w_d_req  = dREN | dWEN;
  assign w_d_idx  = daddr[MEM_AW+1:2];
  assign w_i_idx  = iaddr[MEM_AW+1:2];
  // Upper address bits and byte offset are ignored, so addresses alias.
  assign w_unused = ^{daddr[31:MEM_AW+2], daddr[1:0], iaddr[31:MEM_AW+2], iaddr[1:0]};

`ifdef CACHE_MEM_RR_ARB_EN
  typedef enum logic {GRANT_D, GRANT_I} grant_t;
  grant_t r_last_grant, w_last_grant_nxt;

  // On contention the port that did not win last time is granted.
  assign w_grant_d = w_d_req && (!iREN || (r_last_grant == GRANT_I));

  always_comb begin
    w_last_grant_nxt = r_last_grant;
    if (r_state == IDLE) begin
      if (w_grant_d)
        w_last_grant_nxt = GRANT_D;
      else if (iREN)
        w_last_grant_nxt = GRANT_I;
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST)
      r_last_grant <= GRANT_I;
    else
      r_last_grant <= w_last_grant_nxt;
  end
`else
  assign w_grant_d = w_d_req;
`endif

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_idx   <= '0;
      r_wr    <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_idx   <= w_idx_nxt;
      r_wr    <= w_wr_nxt;
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      for (int unsigned k = 0; k < DEPTH; k++)
        r_mem[k] <= '0;
    end else if (w_mem_we) begin
      r_mem[r_idx] <= dstore;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_idx_nxt   = r_idx;
    w_wr_nxt    = r_wr;
    w_mem_we    = 1'b0;
    dwait       = 1'b1;
    iwait       = 1'b1;
    dload       = '0;
    iload       = '0;

    unique case (r_state)
      IDLE: begin
        // The grant cycle itself counts as wait cycle 1.
        if (w_grant_d) begin
          w_idx_nxt   = w_d_idx;
          w_wr_nxt    = dWEN;
          w_cnt_nxt   = 4'd1;
          w_state_nxt = D_BUSY;
        end else if (iREN) begin
          w_idx_nxt   = w_i_idx;
          w_wr_nxt    = 1'b0;
          w_cnt_nxt   = 4'd1;
          w_state_nxt = I_BUSY;
        end
      end

      D_BUSY: begin
        if (!w_d_req) begin
          w_state_nxt = IDLE;
        end else if ((w_d_idx != r_idx) || (dWEN != r_wr)) begin
          w_idx_nxt = w_d_idx;
          w_wr_nxt  = dWEN;
          w_cnt_nxt = 4'd1;
        end else if (r_cnt == LAT_C) begin
          dwait       = 1'b0;
          dload       = r_wr ? '0 : r_mem[r_idx];
          w_mem_we    = r_wr;
          w_state_nxt = IDLE;
        end else begin
          w_cnt_nxt = r_cnt + 4'd1;
        end
      end

      I_BUSY: begin
        if (!iREN) begin
          w_state_nxt = IDLE;
        end else if (w_i_idx != r_idx) begin
          w_idx_nxt = w_i_idx;
          w_cnt_nxt = 4'd1;
        end else if (r_cnt == LAT_C) begin
          iwait       = 1'b0;
          iload       = r_mem[r_idx];
          w_state_nxt = IDLE;
        end else begin
          w_cnt_nxt = r_cnt + 4'd1;
        end
      end

      default: w_state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_cache_mem_responder.sv
// Bench for cache_mem_responder: directed scenarios plus randomized accesses
// checked against a word-array memory model and the fixed-latency rule.
module tb_cache_mem_responder;

  localparam int LAT    = 2;
  localparam int MEM_AW = 8;

  logic        CLK = 1'b0;
  logic        nRST;
  logic        dREN, dWEN, iREN;
  logic [31:0] daddr, dstore, iaddr;
  logic        dwait, iwait;
  logic [31:0] dload, iload;

  int checks = 0;
  int errors = 0;

  logic [31:0] model [1 << MEM_AW];

  cache_mem_responder #(.LAT(LAT), .MEM_AW(MEM_AW)) dut (
    .CLK(CLK), .nRST(nRST),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
    .dwait(dwait), .dload(dload),
    .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload)
  );

  always #5 CLK = ~CLK;

  function automatic int widx(input logic [31:0] a);
    return int'(a[MEM_AW+1:2]);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle();
    dREN = 1'b0; dWEN = 1'b0; iREN = 1'b0;
    step();
  endtask

  // Called at the start of cycle c0 with a request already driven.
  task automatic wait_done(input bit is_d, input int c0, output int cyc,
                           output logic [31:0] ld, output bit leak);
    int c;
    bit done;
    c = c0; done = 1'b0; cyc = -1; ld = '0; leak = 1'b0;
    while (!done && c < c0 + 40) begin
      @(negedge CLK);
      if (is_d ? !dwait : !iwait) begin
        done = 1'b1;
        cyc  = c;
        ld   = is_d ? dload : iload;
      end else if ((is_d ? dload : iload) !== 32'h0) begin
        leak = 1'b1;
      end
      step();
      c++;
    end
  endtask

  task automatic access(input string tag, input bit is_d, input bit wr,
                        input logic [31:0] addr, input logic [31:0] data);
    int          cyc;
    logic [31:0] ld;
    logic [31:0] exp_ld;
    bit          leak;
    dREN = is_d & ~wr; dWEN = is_d & wr; daddr = addr; dstore = data;
    iREN = ~is_d;      iaddr = addr;
    exp_ld = wr ? 32'h0 : model[widx(addr)];
    wait_done(is_d, 0, cyc, ld, leak);
    chk({tag, "_lat"}, cyc, LAT);
    chk({tag, "_data"}, ld, exp_ld);
    chk({tag, "_zero_while_wait"}, {31'h0, leak}, 32'h0);
    if (wr) model[widx(addr)] = data;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int          dc, ic, cyc;
    logic [31:0] il, ld, a, v;
    bit          leak, is_d, wr;

    for (int k = 0; k < (1 << MEM_AW); k++) model[k] = '0;
    nRST = 1'b0; dREN = 0; dWEN = 0; iREN = 0;
    daddr = '0; dstore = '0; iaddr = '0;
    repeat (3) @(posedge CLK);
    #1 nRST = 1'b1;

    @(negedge CLK);
    chk("rst_dwait", {31'h0, dwait}, 32'h1);
    chk("rst_iwait", {31'h0, iwait}, 32'h1);
    chk("rst_dload", dload, 32'h0);
    chk("rst_iload", iload, 32'h0);
    step();

    access("wr40", 1, 1, 32'h40, 32'h1234_5678);
    access("rd40", 1, 0, 32'h40, 32'h0);
    idle();

    access("preA", 1, 1, 32'h40, 32'hA);
    access("preB", 1, 1, 32'h44, 32'hB);
    idle();
    dREN = 1'b1; dWEN = 1'b0; daddr = 32'h40;
    for (int c = 0; c < 6; c++) begin
      @(negedge CLK);
      chk($sformatf("fill_dwait_c%0d", c), {31'h0, dwait},
          (c == 2 || c == 5) ? 32'h0 : 32'h1);
      chk($sformatf("fill_dload_c%0d", c), dload,
          (c == 2) ? 32'hA : (c == 5) ? 32'hB : 32'h0);
      step();
      if (c == 2) daddr = 32'h44;
      if (c == 5) dREN = 1'b0;
    end

    access("pre48", 1, 1, 32'h48, 32'hCAFE_0048);
    idle();
    dREN = 1'b1; daddr = 32'h40;
    step();
    daddr = 32'h48;
    wait_done(1, 1, cyc, ld, leak);
    chk("restart_lat", cyc, 3);
    chk("restart_data", ld, model[widx(32'h48)]);
    idle();

    access("pre100", 1, 1, 32'h100, 32'h0BAD_F00D);
    idle();
    dREN = 1'b1; dWEN = 1'b0; daddr = 32'h40; iREN = 1'b1; iaddr = 32'h100;
    dc = -1; ic = -1; il = '0;
    for (int c = 0; c < 10; c++) begin
      @(negedge CLK);
      if (dc < 0 && !dwait) dc = c;
      if (ic < 0 && !iwait) begin ic = c; il = iload; end
      step();
      if (dc >= 0) dREN = 1'b0;
      if (ic >= 0) iREN = 1'b0;
    end
`ifdef CACHE_MEM_RR_ARB_EN
    chk("simul_icyc", ic, 2);
    chk("simul_dcyc", dc, 5);
`else
    chk("simul_dcyc", dc, 2);
    chk("simul_icyc", ic, 5);
`endif
    chk("simul_iload", il, model[widx(32'h100)]);

    dWEN = 1'b1; dREN = 1'b0; daddr = 32'h80; dstore = 32'h55;
    step();
    dWEN = 1'b0;
    step();
    access("abort_rd80", 1, 0, 32'h80, 32'h0);
    chk("abort_mem80", model[widx(32'h80)], 32'h0);
    idle();

    dWEN = 1'b1; daddr = 32'h80; dstore = 32'hFF;
    step();
    nRST = 1'b0;
    #1;
    chk("rstmid_dwait", {31'h0, dwait}, 32'h1);
    chk("rstmid_dload", dload, 32'h0);
    dWEN = 1'b0;
    step();
    nRST = 1'b1;
    for (int k = 0; k < (1 << MEM_AW); k++) model[k] = '0;
    step();
    access("rstmid_rd80", 1, 0, 32'h80, 32'h0);
    access("rstmid_rd40", 1, 0, 32'h40, 32'h0);
    idle();

    access("alias_wr400", 1, 1, 32'h400, 32'h1234);
    access("alias_rd000", 1, 0, 32'h000, 32'h0);
    chk("alias_model", model[widx(32'h000)], 32'h1234);
    access("alias_i_rd", 0, 0, 32'hFFFF_FC02, 32'h0);

    for (int n = 0; n < 40; n++) begin
      is_d = ($urandom_range(0, 2) != 0);
      wr   = is_d && ($urandom_range(0, 1) == 1);
      a    = ($urandom & 32'hFFFF_F000) | (32'($urandom_range(0, 7)) << 2)
           | 32'($urandom_range(0, 3));
      v    = $urandom;
      access($sformatf("rnd%0d", n), is_d, wr, a, v);
      if ($urandom_range(0, 1) == 1) idle();
    end
    idle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
